// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: waits for each anode dwell to settle,
// decodes the segment pattern back to a hex nibble per digit and publishes full frames.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,   // must be >= 2
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        valid,
    output logic        frame_done,
    output logic        err_seg,
    output logic        err_an
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Synchronizers come out of reset at the bus idle level so a quiet bus
    // is not mistaken for "all anodes active".
    localparam logic [3:0] AN_IDLE  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [3:0]    an_s1, an_s2;
    logic [7:0]    seg_s1, seg_s2;
    logic [11:0]   bus_prev;
    logic [CW-1:0] cnt;
    logic          captured;
    logic [3:0]    seen;

    logic [11:0] bus_cur;
    logic        changed;
    logic        fire;
    logic [3:0]  an_act;
    logic [7:0]  seg_act;
    logic        an_none;
    logic        an_one;
    logic [1:0]  idx;
    logic [4:0]  dec;
    logic        pat_blank;
    logic        pat_ok;
    logic [3:0]  seen_next;

    function automatic logic [4:0] decode_hex(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        bus_cur   = {an_s2, seg_s2};
        changed   = (bus_cur != bus_prev);
        fire      = !changed && (cnt == CNT_MAX) && !captured;
        an_act    = AN_ACTIVE_LOW  ? ~an_s2  : an_s2;
        seg_act   = SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2;
        an_none   = (an_act == 4'b0000);
        an_one    = 1'b1;
        idx       = 2'd0;
        case (an_act)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: an_one = 1'b0;
        endcase
        dec       = decode_hex(seg_act[6:0]);
        pat_blank = (seg_act[6:0] == 7'h00);
        pat_ok    = pat_blank || dec[4];
        seen_next = seen | an_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1      <= AN_IDLE;
            an_s2      <= AN_IDLE;
            seg_s1     <= SEG_IDLE;
            seg_s2     <= SEG_IDLE;
            bus_prev   <= {AN_IDLE, SEG_IDLE};
            cnt        <= '0;
            captured   <= 1'b0;
            seen       <= 4'b0;
            digits     <= 16'h0;
            dp         <= 4'b0;
            blank      <= 4'b0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err_seg    <= 1'b0;
            err_an     <= 1'b0;
        end else begin
            an_s1      <= an;
            an_s2      <= an_s1;
            seg_s1     <= seg;
            seg_s2     <= seg_s1;
            bus_prev   <= bus_cur;
            frame_done <= 1'b0;
            err_seg    <= 1'b0;
            err_an     <= 1'b0;

            if (changed) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // One capture per dwell; captured stays set until the bus moves.
            if (fire) begin
                captured <= 1'b1;
                if (!an_none && !an_one) begin
                    err_an <= 1'b1;
                end else if (an_one) begin
                    if (pat_ok) begin
                        digits[{idx, 2'b00} +: 4] <= pat_blank ? 4'h0 : dec[3:0];
                        blank[idx] <= pat_blank;
                        dp[idx]    <= seg_act[7];
                        if (seen_next == 4'b1111) begin
                            frame_done <= 1'b1;
                            valid      <= 1'b1;
                            seen       <= 4'b0;
                        end else begin
                            seen <= seen_next;
                        end
                    end else begin
                        err_seg <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives active-low scan patterns and
// compares outputs against hand-computed values.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        valid;
    logic        frame_done;
    logic        err_seg;
    logic        err_an;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int es_cnt = 0;
    int ea_cnt = 0;
    int fd0, es0, ea0;

    seg7_scan_decoder #(
        .STABLE_CYCLES (4),
        .AN_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .digits    (digits),
        .dp        (dp),
        .blank     (blank),
        .valid     (valid),
        .frame_done(frame_done),
        .err_seg   (err_seg),
        .err_an    (err_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses are one clock wide, so each appears at exactly one negedge.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (err_seg)    es_cnt++;
        if (err_an)     ea_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        fd0 = fd_cnt;
        es0 = es_cnt;
        ea0 = ea_cnt;
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int cycles);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic scan3(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1);
        drive(4'b0111, s3, 10);
        drive(4'b1011, s2, 10);
        drive(4'b1101, s1, 10);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        #1;
        check("rst_async_outs", {digits, dp, blank, valid, frame_done, err_seg, err_an}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        an    = 4'hF;
        seg   = 8'hFF;
        #1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 16'h0);
        check("rst_flags", {dp, blank, valid, frame_done, err_seg, err_an}, 32'h0);
        rst_n = 1'b1;

        // digit 0 shows "0"
        snap();
        drive(4'b1110, 8'hC0, 8);
        check("t1_digit0", digits[3:0], 4'h0);
        check("t1_blank_dp", {blank, dp}, 8'h00);
        check("t1_valid_fd", {valid, 32'(fd_cnt - fd0)}, 33'h0);

        // capture latency: edges 0..5 keep the old value, edge 6 publishes "7"
        @(negedge clk);
        seg = 8'hF8;
        repeat (6) @(negedge clk);
        check("lat_edge5_old", digits[3:0], 4'h0);
        @(negedge clk);
        check("lat_edge6_new", digits[3:0], 4'h7);
        repeat (4) @(negedge clk);

        apply_reset();

        // full scan 1234
        snap();
        scan3(8'hF9, 8'hA4, 8'hB0);
        check("scan_no_valid_yet", valid, 1'b0);
        drive(4'b1110, 8'h99, 10);
        check("scan_digits", digits, 16'h1234);
        check("scan_fd_once", 32'(fd_cnt - fd0), 32'd1);
        check("scan_valid", valid, 1'b1);
        check("scan_blank_dp", {blank, dp}, 8'h00);

        // digit 2 blank with dp lit
        snap();
        scan3(8'hF9, 8'h7F, 8'hB0);
        drive(4'b1110, 8'h99, 10);
        check("blank_digits", digits, 16'h1034);
        check("blank_mask", blank, 4'b0100);
        check("blank_dp", dp, 4'b0100);
        check("blank_fd", 32'(fd_cnt - fd0), 32'd1);

        // two anodes active
        snap();
        drive(4'b1100, 8'hF9, 10);
        check("erran_pulse", 32'(ea_cnt - ea0), 32'd1);
        check("erran_digits", digits, 16'h1034);
        scan3(8'h92, 8'h82, 8'hF8);
        check("erran_no_fd", 32'(fd_cnt - fd0), 32'd0);
        check("erran_digits2", digits, 16'h5674);

        // "8" with dp on digit 1, then invalid pattern on digit 0
        snap();
        drive(4'b1101, 8'h00, 10);
        check("eight_digits", digits, 16'h5684);
        check("eight_dp", dp, 4'b0010);
        drive(4'b1110, 8'hAA, 10);
        check("errseg_pulse", 32'(es_cnt - es0), 32'd1);
        check("errseg_digits", digits, 16'h5684);
        check("errseg_dp_blank", {dp, blank}, 8'h20);
        check("errseg_no_fd", 32'(fd_cnt - fd0), 32'd0);

        // glitch during a digit-0 dwell
        snap();
        drive(4'b1110, 8'h99, 10);
        check("glitch_fd", 32'(fd_cnt - fd0), 32'd1);
        drive(4'b1110, 8'h92, 2);
        drive(4'b1110, 8'h99, 3);
        check("glitch_no_capture", digits[3:0], 4'h4);
        repeat (7) @(negedge clk);
        check("glitch_no_err", 32'((es_cnt - es0) + (ea_cnt - ea0)), 32'd0);
        check("glitch_digits", digits, 16'h5684);

        // reset in the middle of a frame
        drive(4'b0111, 8'hF9, 10);
        drive(4'b1011, 8'hA4, 10);
        apply_reset();
        snap();
        scan3(8'h90, 8'h88, 8'h83);
        check("midrst_no_fd", 32'(fd_cnt - fd0), 32'd0);
        check("midrst_valid0", valid, 1'b0);
        drive(4'b1110, 8'hC6, 10);
        check("midrst_fd", 32'(fd_cnt - fd0), 32'd1);
        check("midrst_valid1", valid, 1'b1);
        check("midrst_digits", digits, 16'h9ABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive end of the multiplexed 7-segment display bus that our display drivers produce on an/seg.
- Samples the scanned anode/segment lines, waits until each digit dwell is stable, then decodes the segment pattern back to a hex nibble per digit.
- Publishes the reconstructed 4-digit value once every digit has been seen.
- Used for board-to-board loopback and as a self-checking monitor in the counter/Fibonacci benches.

Parameters:
STABLE_CYCLES, 4, consecutive synced cycles an/seg must hold before capture (min 2).
AN_ACTIVE_LOW, 1, 1 = anode line low selects the digit.
SEG_ACTIVE_LOW, 1, 1 = segment line low lights the segment.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
an  input  4  scanned anode lines; an[0] = rightmost digit
seg  input  8  seg[0]=a .. seg[6]=g, seg[7]=dp
digits  output  16  decoded value; digits[4i+3:4i] = digit i
dp  output  4  decimal point state per digit, 1 = lit
blank  output  4  1 = digit i was last seen with no segments lit
valid  output  1  high once a full frame has been captured since reset
frame_done  output  1  one-cycle pulse when all 4 digits captured
err_seg  output  1  one-cycle pulse: stable pattern not in decode table
err_an  output  1  one-cycle pulse: stable dwell with >1 anode active

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Internal state cleared: sync flops, stability counter, seen mask, captured flag. Effect is immediate and holds until rst_n rises. Reset mid-frame discards partial frame.
- Input path: an and seg pass through a 2-flop synchronizer, then are normalized to active-high using the parameters.
- Stability counter:
  - Cleared when synced {an,seg} differs from its previous-cycle value; otherwise increments, saturating.
  - Dwell is stable when the counter reaches STABLE_CYCLES-1.
- Capture: exactly one event per stable dwell; the captured flag blocks re-capture until {an,seg} changes. An input change registered at edge 0 and held updates outputs at edge STABLE_CYCLES+2.
- Capture outcomes by anode count:
  - 0 anodes active: no action; bus is idle.
  - >1 anodes active: err_an pulse; nothing stored.
  - Exactly 1 active (digit i), decode segments g..a (active-high hex):
    - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
    - Pattern 00 (blank): nibble i := 0, blank[i] := 1.
    - Decoded pattern: nibble i := value, blank[i] := 0.
    - Any other pattern: err_seg pulse; nibble i, blank[i], dp[i] and seen[i] are unchanged.
    - On a successful decode or blank: dp[i] := seg dp bit, and seen[i] := 1.
- Frame completion: the cycle seen becomes 4'b1111:
  - frame_done pulses for 1 cycle;
  - valid is set and stays 1 until reset;
  - seen is cleared in the same cycle.
- A digit re-captured before the frame completes overwrites its nibble; seen is unaffected.
- digits, dp and blank update per digit at capture time, not held until frame end.
- Glitch shorter than STABLE_CYCLES: the counter restarts and no capture occurs. A glitch that returns to the same digit pattern causes a second capture of the same value, which is harmless.
- Scan order is arbitrary; no ordering is checked.

Test Plan:
- Reset then an=1110, seg=0xC0 (active-low "0") held 8 cycles -> digits[3:0]=0 at edge STABLE_CYCLES+2=6; valid=0, frame_done=0.
- Scan digits 3..0 with patterns "1","2","3","4" (seg 0xF9,0xA4,0xB0,0x99), 10 cycles each -> digits=16'h1234, one frame_done pulse, valid=1.
- Same scan but digit 2 with seg=0xFF and dp bit low (seg=0x7F) -> blank=4'b0100, dp=4'b0100, digits[11:8]=0.
- an=1100 held 10 cycles -> single err_an pulse; digits unchanged; no frame_done after scanning the other three digits.
- Digit 1 seg=0x00 (all lit plus dp; g..a=7F, "8") with dp lit, then seg=0xAA (invalid) on digit 0 -> err_seg pulse once; digits[3:0] retains prior value.
- 2-cycle glitch on seg during a dwell -> no extra err pulses.
- Reset asserted mid-frame after 2 digits, then release and scan 4 digits -> frame_done only after all 4 post-reset digits; valid=0 until then.
